// File: rtl/uart_cmd_if.sv
// Byte-in / status-out bundle between the UART receiver side and the command decoder.
// Handshake: rx_done is a one-cycle valid strobe with no ready back-channel; the
// consumer must take rx_data and parity_error in the same cycle rx_done is high.
interface uart_cmd_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_error;
  logic [2:0] fire_code;
  logic       code_valid;
  logic       fire;
  logic       frame_err;
  logic [1:0] err_type;
  logic [7:0] err_count;

  modport master (
    output rx_data, rx_done, parity_error,
    input  fire_code, code_valid, fire, frame_err, err_type, err_count
  );

  modport slave (
    input  rx_data, rx_done, parity_error,
    output fire_code, code_valid, fire, frame_err, err_type, err_count
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses {SYNC, CMD, ~CMD} byte frames, holds the selected firing code, generates a
// fixed-width fire pulse, and strobes/counts framing errors.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE         = 8'hA5,
  parameter int         TIMEOUT_CYCLES    = 4800,
  parameter int         FIRE_PULSE_CYCLES = 48
) (
  input  logic       clk,
  input  logic       reset,
  uart_cmd_if.slave  bus,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_WAIT_SYNC = 2'd0;
  localparam logic [1:0] S_WAIT_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT_CHK  = 2'd2;

  localparam logic [1:0] E_PARITY   = 2'd0;
  localparam logic [1:0] E_TIMEOUT  = 2'd1;
  localparam logic [1:0] E_CHECKSUM = 2'd2;
  localparam logic [1:0] E_BAD_CMD  = 2'd3;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PW = (FIRE_PULSE_CYCLES > 1) ? $clog2(FIRE_PULSE_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(FIRE_PULSE_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] pulse_q;
  logic          fire_q;
  logic [2:0]    code_q;
  logic          code_valid_q;
  logic          ferr_q;
  logic [1:0]    etype_q, etype_d;
  logic [7:0]    ecount_q;
  logic          err_d;
  logic          set_ok;
  logic          fire_ok;

  // Frame FSM, inter-byte timeout and command validation; rx_done beats a
  // same-cycle timeout expiry because the timeout branch is only taken without it.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tmo_d   = tmo_q;
    etype_d = etype_q;
    err_d   = 1'b0;
    set_ok  = 1'b0;
    fire_ok = 1'b0;
    if (bus.rx_done) begin
      tmo_d = '0;
      if (bus.parity_error) begin
        err_d   = 1'b1;
        etype_d = E_PARITY;
        state_d = S_WAIT_SYNC;
      end else begin
        case (state_q)
          S_WAIT_SYNC: if (bus.rx_data == SYNC_BYTE) state_d = S_WAIT_CMD;
          S_WAIT_CMD: begin
            cmd_d   = bus.rx_data;
            state_d = S_WAIT_CHK;
          end
          S_WAIT_CHK: begin
            state_d = S_WAIT_SYNC;
            if (bus.rx_data != ~cmd_q) begin
              err_d   = 1'b1;
              etype_d = E_CHECKSUM;
            end else if (cmd_q[7:4] == 4'h1) begin
              if (!cmd_q[3] && (cmd_q[2:0] <= 3'd5)) begin
                set_ok = 1'b1;
              end else begin
                err_d   = 1'b1;
                etype_d = E_BAD_CMD;
              end
            end else if (cmd_q[7:4] == 4'h2) begin
              if ((cmd_q[3:0] == 4'h0) && code_valid_q && !fire_q) begin
                fire_ok = 1'b1;
              end else begin
                err_d   = 1'b1;
                etype_d = E_BAD_CMD;
              end
            end else begin
              err_d   = 1'b1;
              etype_d = E_BAD_CMD;
            end
          end
          default: state_d = S_WAIT_SYNC;
        endcase
      end
    end else if (state_q != S_WAIT_SYNC) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        etype_d = E_TIMEOUT;
        state_d = S_WAIT_SYNC;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Frame state, latched command and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT_SYNC;
      cmd_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
    end
  end

  // Firing code register and fixed-width fire pulse; a new code may land mid-pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q       <= '0;
      code_valid_q <= 1'b0;
      fire_q       <= 1'b0;
      pulse_q      <= '0;
    end else begin
      if (set_ok) begin
        code_q       <= cmd_q[2:0];
        code_valid_q <= 1'b1;
      end
      if (fire_ok) begin
        fire_q  <= 1'b1;
        pulse_q <= PULSE_LAST;
      end else if (fire_q) begin
        if (pulse_q == '0) fire_q <= 1'b0;
        else               pulse_q <= pulse_q - 1'b1;
      end
    end
  end

  // Error strobe, sticky error type and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_q   <= 1'b0;
      etype_q  <= '0;
      ecount_q <= '0;
    end else begin
      ferr_q  <= err_d;
      etype_q <= etype_d;
      if (err_d && (ecount_q != 8'hFF)) ecount_q <= ecount_q + 8'd1;
    end
  end

  assign bus.fire_code  = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.fire       = fire_q;
  assign bus.frame_err  = ferr_q;
  assign bus.err_type   = etype_q;
  assign bus.err_count  = ecount_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: frame decoding, errors, timeout, pulse width, reset.
module tb_uart_cmd_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] state;
  int         n_tests;
  int         n_fail;
  int         exp_cnt;
  int         width;
  logic [1:0] exp_q[$];

  uart_cmd_if bus ();

  uart_cmd_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 0;
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic par);
    @(posedge clk);
    #1;
    bus.rx_data      = b;
    bus.rx_done      = 1'b1;
    bus.parity_error = par;
    @(posedge clk);
    #1;
    bus.rx_done      = 1'b0;
    bus.parity_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic expect_err(input logic [1:0] t);
    exp_q.push_back(t);
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic measure_fire(output int n);
    n = 0;
    while (bus.fire && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Scoreboard: every frame_err strobe must match the next queued error type
  always @(negedge clk) begin
    if (bus.frame_err) begin
      if (exp_q.size() == 0) check("unexpected_frame_err", {30'd0, bus.err_type}, 32'hFFFF);
      else                   check("err_type_strobe", {30'd0, bus.err_type}, {30'd0, exp_q.pop_front()});
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    bus.rx_data      = 8'h00;
    bus.rx_done      = 1'b0;
    bus.parity_error = 1'b0;
    do_reset();

    check("rst_fire_code", bus.fire_code, 0);
    check("rst_code_valid", bus.code_valid, 0);
    check("rst_fire", bus.fire, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_err_type", bus.err_type, 0);
    check("rst_err_count", bus.err_count, 0);
    check("rst_state", state, 0);

    // 1: set code 3, fire, 48-cycle pulse
    send_frame(8'hA5, 8'h13, 8'hEC);
    check("t1_code", bus.fire_code, 3);
    check("t1_valid", bus.code_valid, 1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h20, 1'b0);
    check("t1_fire_pre", bus.fire, 0);
    send_byte(8'hDF, 1'b0);
    check("t1_fire_start", bus.fire, 1);
    measure_fire(width);
    check("t1_pulse_width", width, 48);
    check("t1_err_count", bus.err_count, 0);

    // 1b: SET_CODE accepted mid-pulse, FIRE rejected mid-pulse, pulse width kept
    send_frame(8'hA5, 8'h20, 8'hDF);
    check("t1b_fire_start", bus.fire, 1);
    send_frame(8'hA5, 8'h11, 8'hEE);
    check("t1b_code_mid_pulse", bus.fire_code, 1);
    expect_err(2'd3);
    send_frame(8'hA5, 8'h20, 8'hDF);
    check("t1b_refire_err_type", bus.err_type, 3);
    check("t1b_fire_kept", bus.fire, 1);
    measure_fire(width);
    check("t1b_pulse_width", width + 12, 48);

    // 2: FIRE without a code after fresh reset
    do_reset();
    expect_err(2'd3);
    send_frame(8'hA5, 8'h20, 8'hDF);
    check("t2_frame_err", bus.frame_err, 1);
    check("t2_err_type", bus.err_type, 3);
    check("t2_err_count", bus.err_count, 1);
    check("t2_fire", bus.fire, 0);
    @(posedge clk);
    #1;
    check("t2_strobe_1cyc", bus.frame_err, 0);
    check("t2_type_held", bus.err_type, 3);

    // 3: code out of range, checksum, CMD[3] set, unknown opcode
    send_frame(8'hA5, 8'h13, 8'hEC);
    check("t3_code3", bus.fire_code, 3);
    expect_err(2'd3);
    send_frame(8'hA5, 8'h16, 8'hE9);
    check("t3_code6_type", bus.err_type, 3);
    check("t3_code6_keep", bus.fire_code, 3);
    expect_err(2'd2);
    send_frame(8'hA5, 8'h13, 8'h00);
    check("t3_chk_type", bus.err_type, 2);
    check("t3_chk_keep", bus.fire_code, 3);
    expect_err(2'd3);
    send_frame(8'hA5, 8'h1B, 8'hE4);
    check("t3_bit3_type", bus.err_type, 3);
    expect_err(2'd3);
    send_frame(8'hA5, 8'h30, 8'hCF);
    check("t3_opcode_type", bus.err_type, 3);
    check("t3_err_count", bus.err_count, exp_cnt);

    // 4: inter-byte timeout, recovery, garbage before SYNC, rx_done wins at expiry
    expect_err(2'd1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h12, 1'b0);
    repeat (4799) @(posedge clk);
    #1;
    check("t4_tmo_early", bus.frame_err, 0);
    @(posedge clk);
    #1;
    check("t4_tmo_strobe", bus.frame_err, 1);
    check("t4_tmo_type", bus.err_type, 1);
    check("t4_tmo_state", state, 0);
    send_frame(8'hA5, 8'h13, 8'hEC);
    check("t4_after_tmo_code", bus.fire_code, 3);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(8'hA5, 8'h11, 8'hEE);
    check("t4_garbage_code", bus.fire_code, 1);
    check("t4_garbage_count", bus.err_count, exp_cnt);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h14, 1'b0);
    repeat (4798) @(posedge clk);
    send_byte(8'hEB, 1'b0);
    check("t4_race_code", bus.fire_code, 4);
    check("t4_race_count", bus.err_count, exp_cnt);

    // 5: parity error on CMD, then error counter saturation
    expect_err(2'd0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h13, 1'b1);
    check("t5_par_type", bus.err_type, 0);
    check("t5_par_state", state, 0);
    send_byte(8'hEC, 1'b0);
    check("t5_par_code_keep", bus.fire_code, 4);
    for (int i = 0; i < 300; i++) begin
      expect_err(2'd0);
      send_byte(8'h5A, 1'b1);
    end
    check("t5_sat_count", bus.err_count, 255);

    // 6: reset in the middle of a pulse
    send_frame(8'hA5, 8'h15, 8'hEA);
    check("t6_code5", bus.fire_code, 5);
    send_frame(8'hA5, 8'h20, 8'hDF);
    repeat (10) @(posedge clk);
    #2;
    check("t6_fire_mid", bus.fire, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_fire", bus.fire, 0);
    check("t6_rst_code", bus.fire_code, 0);
    check("t6_rst_valid", bus.code_valid, 0);
    check("t6_rst_err_count", bus.err_count, 0);
    check("t6_rst_err_type", bus.err_type, 0);
    check("t6_rst_state", state, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_post_fire", bus.fire, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
